// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch path: state encoding, instruction field positions and the NOP
// word.
package cpu_pkg;

    localparam int unsigned XLen = 32;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StHold = 2'd2;
    localparam logic [1:0] StErr  = 2'd3;

    localparam int unsigned Imm16Msb    = 15;
    localparam int unsigned Imm16Lsb    = 0;
    localparam int unsigned Target26Msb = 25;
    localparam int unsigned Target26Lsb = 0;

    localparam logic [XLen-1:0] NopInstr = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [XLen-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational next-PC candidates derived from a PC and the instruction fetched from it.
module branch_target_calc
    import cpu_pkg::*;
(
    input  logic [XLen-1:0] pc,
    input  logic [XLen-1:0] instr,
    output logic [XLen-1:0] pc_plus4,
    output logic [XLen-1:0] branch_pc,
    output logic [XLen-1:0] jmp_pc
);

    logic [XLen-1:0] imm_ext;
    logic            unused_opcode;

    assign pc_plus4  = pc + 32'd4;
    assign imm_ext   = {{16{instr[Imm16Msb]}}, instr[Imm16Msb:Imm16Lsb]};
    assign branch_pc = pc_plus4 + (imm_ext << 2);
    assign jmp_pc    = {pc_plus4[31:28], instr[Target26Msb:Target26Lsb], 2'b00};

    // Opcode bits play no part in target generation.
    assign unused_opcode = ^instr[31:26];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: requests the word at PC, holds it for decode with its branch/jump targets, and
// stalls the PC register while a fetch is outstanding.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     TIMEOUT_CYCLES = 16,
    parameter logic [XLen-1:0] NOP_INSTR      = NopInstr
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [XLen-1:0] PC,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLen-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLen-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLen-1:0] instr,
    output logic [XLen-1:0] fetch_pc,
    output logic [XLen-1:0] pc_plus4,
    output logic [XLen-1:0] branch_pc,
    output logic [XLen-1:0] jmp_pc,
    output logic            stall,
    output logic            fetch_err
);

    localparam logic [7:0] TimeoutLim = 8'(TIMEOUT_CYCLES);

    logic [1:0]      state_q, state_d;
    logic [XLen-1:0] addr_q, addr_d;
    logic [XLen-1:0] instr_q, instr_d;
    logic [XLen-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLen-1:0] pc_plus4_q, pc_plus4_d;
    logic [XLen-1:0] branch_pc_q, branch_pc_d;
    logic [XLen-1:0] jmp_pc_q, jmp_pc_d;
    logic            err_q, err_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            kill_q, kill_d;

    logic [7:0]      cnt_inc;
    logic            kill_eff;
    logic [XLen-1:0] calc_pc_plus4;
    logic [XLen-1:0] calc_branch_pc;
    logic [XLen-1:0] calc_jmp_pc;

    // Targets are computed from the word on the bus so they register in the same edge as instr.
    branch_target_calc u_branch_target_calc (
        .pc       (addr_q),
        .instr    (imem_rdata),
        .pc_plus4 (calc_pc_plus4),
        .branch_pc(calc_branch_pc),
        .jmp_pc   (calc_jmp_pc)
    );

    assign cnt_inc  = cnt_q + 8'd1;
    // A flush arriving alongside the data also makes that data stale.
    assign kill_eff = kill_q | flush;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        fetch_pc_d  = fetch_pc_q;
        pc_plus4_d  = pc_plus4_q;
        branch_pc_d = branch_pc_q;
        jmp_pc_d    = jmp_pc_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        kill_d      = kill_q;

        case (state_q)
            StIdle: begin
                addr_d = PC;
                cnt_d  = 8'd0;
                kill_d = 1'b0;
                if (is_misaligned(PC)) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (imem_ready) begin
                    cnt_d  = 8'd0;
                    kill_d = 1'b0;
                    if (kill_eff) begin
                        state_d = StIdle;
                    end else begin
                        state_d     = StHold;
                        instr_d     = imem_rdata;
                        fetch_pc_d  = addr_q;
                        pc_plus4_d  = calc_pc_plus4;
                        branch_pc_d = calc_branch_pc;
                        jmp_pc_d    = calc_jmp_pc;
                    end
                end else if (cnt_inc == TimeoutLim) begin
                    cnt_d   = cnt_inc;
                    kill_d  = 1'b0;
                    state_d = StErr;
                    err_d   = 1'b1;
                end else begin
                    cnt_d  = cnt_inc;
                    kill_d = kill_eff;
                end
            end
            StHold: begin
                if (flush || instr_ready) begin
                    state_d = StIdle;
                    instr_d = NOP_INSTR;
                end
            end
            StErr: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            instr_q     <= NOP_INSTR;
            fetch_pc_q  <= '0;
            pc_plus4_q  <= '0;
            branch_pc_q <= '0;
            jmp_pc_q    <= '0;
            err_q       <= 1'b0;
            cnt_q       <= 8'd0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            fetch_pc_q  <= fetch_pc_d;
            pc_plus4_q  <= pc_plus4_d;
            branch_pc_q <= branch_pc_d;
            jmp_pc_q    <= jmp_pc_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            kill_q      <= kill_d;
        end
    end

    assign imem_req    = (state_q == StReq);
    assign imem_addr   = addr_q;
    assign instr_valid = (state_q == StHold);
    assign stall       = (state_q != StHold);
    assign instr       = instr_q;
    assign fetch_pc    = fetch_pc_q;
    assign pc_plus4    = pc_plus4_q;
    assign branch_pc   = branch_pc_q;
    assign jmp_pc      = jmp_pc_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vectors, flush/timeout/misalignment
// sequences and randomized fetches checked against a transaction-level model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] Nop = 32'h0000_0000;
    localparam int          Timeout = 16;

    logic        CLK;
    logic        RST;
    logic [31:0] PC;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] fetch_pc;
    logic [31:0] pc_plus4;
    logic [31:0] branch_pc;
    logic [31:0] jmp_pc;
    logic        stall;
    logic        fetch_err;

    int n_tests = 0;
    int n_fail  = 0;

    instruction_fetch_unit #(
        .TIMEOUT_CYCLES(Timeout),
        .NOP_INSTR     (Nop)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PC         (PC),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .fetch_pc   (fetch_pc),
        .pc_plus4   (pc_plus4),
        .branch_pc  (branch_pc),
        .jmp_pc     (jmp_pc),
        .stall      (stall),
        .fetch_err  (fetch_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        int          lat;
        int          hold;
        int          exitm;   // 0: instr_ready, 1: flush, 2: both
        logic [31:0] e_p4;
        logic [31:0] e_br;
        logic [31:0] e_jmp;
    } vec_t;

    // Reference target arithmetic, straight from the instruction-format definitions.
    function automatic logic [31:0] m_p4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] m_br(input logic [31:0] pc, input logic [31:0] ins);
        logic [31:0] off;
        off = (ins[15] ? (ins | 32'hFFFF_0000) : (ins & 32'h0000_FFFF)) * 32'd4;
        return pc + 32'd4 + off;
    endfunction

    function automatic logic [31:0] m_jmp(input logic [31:0] pc, input logic [31:0] ins);
        return ((pc + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        flush = 1'b0;
        imem_ready = 1'b0;
        instr_ready = 1'b0;
        step();
        step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, Nop);
        chk("rst_fetch_pc", fetch_pc, 32'd0);
        chk("rst_pc_plus4", pc_plus4, 32'd0);
        chk("rst_branch", branch_pc, 32'd0);
        chk("rst_jmp", jmp_pc, 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd1);
        RST = 1'b0;
    endtask

    // Entered and left with the DUT in IDLE at the sample point.
    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] rdata, input int lat,
                            input int hold, input int exitm, input logic idle_flush,
                            input logic [31:0] e_p4, input logic [31:0] e_br,
                            input logic [31:0] e_jmp);
        PC = pc;
        flush = idle_flush;
        instr_ready = 1'b0;
        imem_ready = 1'b0;
        chk("idle_req", 32'(imem_req), 32'd0);
        chk("idle_valid", 32'(instr_valid), 32'd0);
        chk("idle_stall", 32'(stall), 32'd1);
        for (int k = 0; k <= lat; k++) begin
            step();
            flush = 1'b0;
            chk("req_req", 32'(imem_req), 32'd1);
            chk("req_addr", imem_addr, pc);
            chk("req_stall", 32'(stall), 32'd1);
            chk("req_valid", 32'(instr_valid), 32'd0);
            chk("req_err", 32'(fetch_err), 32'd0);
            imem_ready = (k == lat);
            imem_rdata = (k == lat) ? rdata : $urandom();
        end
        step();
        imem_ready = 1'b0;
        imem_rdata = $urandom();
        for (int h = 0; h <= hold; h++) begin
            PC = $urandom() & 32'hFFFF_FFFC;
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_stall", 32'(stall), 32'd0);
            chk("hold_req", 32'(imem_req), 32'd0);
            chk("hold_instr", instr, rdata);
            chk("hold_fetch_pc", fetch_pc, pc);
            chk("hold_pc_plus4", pc_plus4, e_p4);
            chk("hold_branch", branch_pc, e_br);
            chk("hold_jmp", jmp_pc, e_jmp);
            chk("hold_err", 32'(fetch_err), 32'd0);
            if (h < hold) step();
        end
        instr_ready = (exitm != 1);
        flush = (exitm != 0);
        step();
        instr_ready = 1'b0;
        flush = 1'b0;
        chk("exit_valid", 32'(instr_valid), 32'd0);
        chk("exit_instr", instr, Nop);
        chk("exit_stall", 32'(stall), 32'd1);
        chk("exit_req", 32'(imem_req), 32'd0);
    endtask

    // Flush during REQ; the handshake completes and the data is dropped.
    task automatic do_killed(input logic [31:0] pc, input int flush_k, input int lat,
                             input logic [31:0] junk);
        PC = pc;
        flush = 1'b0;
        imem_ready = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            step();
            chk("kill_req", 32'(imem_req), 32'd1);
            chk("kill_addr", imem_addr, pc);
            chk("kill_valid", 32'(instr_valid), 32'd0);
            flush = (k == flush_k);
            imem_ready = (k == lat);
            imem_rdata = junk;
        end
        step();
        imem_ready = 1'b0;
        flush = 1'b0;
        chk("kill_done_valid", 32'(instr_valid), 32'd0);
        chk("kill_done_req", 32'(imem_req), 32'd0);
        chk("kill_done_instr", instr, Nop);
        chk("kill_done_err", 32'(fetch_err), 32'd0);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{32'h0040_0000, 32'h1000_FFFF, 0, 1, 0,
                    32'h0040_0004, 32'h0040_0000, 32'h0003_FFFC};
        vecs[1] = '{32'h0040_0004, 32'h1234_5678, 5, 0, 0,
                    32'h0040_0008, 32'h0041_59E8, 32'h08D1_59E0};
        vecs[2] = '{32'hFFFF_FFFC, 32'h0C00_0010, 1, 2, 2,
                    32'h0000_0000, 32'h0000_0040, 32'h0000_0040};
        vecs[3] = '{32'h8000_0100, 32'hFFFF_8000, 15, 0, 1,
                    32'h8000_0104, 32'h7FFE_0104, 32'h8FFE_0000};

        RST = 1'b1;
        PC = 32'd0;
        flush = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        instr_ready = 1'b0;
        do_reset();

        for (int i = 0; i < 4; i++) begin
            do_fetch(vecs[i].pc, vecs[i].rdata, vecs[i].lat, vecs[i].hold, vecs[i].exitm,
                     1'b0, vecs[i].e_p4, vecs[i].e_br, vecs[i].e_jmp);
        end

        // Flush in REQ, data three cycles later is discarded, next fetch uses the new PC.
        do_killed(32'h0040_0010, 0, 3, 32'hDEAD_BEEF);
        do_fetch(32'h0050_0000, 32'h0000_0003, 2, 0, 0, 1'b1,
                 m_p4(32'h0050_0000), m_br(32'h0050_0000, 32'h0000_0003),
                 m_jmp(32'h0050_0000, 32'h0000_0003));

        // Memory never answers: error after exactly Timeout REQ cycles, sticky until reset.
        PC = 32'h0000_1000;
        for (int k = 0; k < Timeout; k++) begin
            step();
            chk("to_req", 32'(imem_req), 32'd1);
            chk("to_err_early", 32'(fetch_err), 32'd0);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            chk("to_err", 32'(fetch_err), 32'd1);
            chk("to_req_off", 32'(imem_req), 32'd0);
            chk("to_stall", 32'(stall), 32'd1);
            chk("to_valid", 32'(instr_valid), 32'd0);
            flush = 1'b1;
            imem_ready = 1'b1;
            step();
        end
        do_reset();

        // Misaligned PC: straight to error, never requests.
        PC = 32'h0040_0002;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mis_req", 32'(imem_req), 32'd0);
            chk("mis_err", 32'(fetch_err), 32'd1);
            chk("mis_stall", 32'(stall), 32'd1);
        end
        do_reset();

        for (int i = 0; i < 40; i++) begin
            logic [31:0] pc;
            logic [31:0] rd;
            int          lat;
            pc  = $urandom() & 32'hFFFF_FFFC;
            if (i % 8 == 7) pc = 32'hFFFF_FFF0 | (pc & 32'h0000_000C);
            rd  = $urandom();
            lat = int'($urandom_range(0, Timeout - 1));
            if (i % 5 == 4 && lat > 0) begin
                do_killed(pc, int'($urandom_range(0, lat - 1)), lat, rd);
            end else begin
                do_fetch(pc, rd, lat, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                         1'($urandom_range(0, 1)), m_p4(pc), m_br(pc, rd), m_jmp(pc, rd));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
